// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one 16-byte bundle request at a
// time and hands each returned bundle to the core as a one-cycle write strobe.
// Optional build macro FETCH_PERF_EN adds bundle/squash performance counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_stop_fetch,
  input  logic          i_jump,
  input  logic          i_jump_accept,
  input  logic [31:0]   i_jump_addr,
  output logic          o_imem_req,
  output logic [31:0]   o_imem_addr,
  input  logic          i_imem_gnt,
  input  logic          i_imem_valid,
  input  logic [127:0]  i_imem_rdata,
  output logic [127:0]  o_fetch_data,
  output logic          o_fetch_write,
  output logic [31:0]   o_fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   o_perf_bundles,
  output logic [15:0]   o_perf_squash
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]   r_state, w_state_d;
  logic [31:0]  r_pc, w_pc_d;
  logic [1:0]   r_skip, w_skip_d;
  logic [127:0] r_hold, w_hold_d;
  logic [31:0]  r_hold_pc, w_hold_pc_d;
  logic [127:0] r_fetch_data, w_fetch_data_d;
  logic         r_fetch_write, w_fetch_write_d;
  logic [31:0]  r_fetch_pc, w_fetch_pc_d;
  logic         w_redirect;
  logic [127:0] w_bundle;
  logic         w_unused;

  assign w_redirect = i_jump & i_jump_accept;
  // Byte offset within a word carries no meaning for 32-bit instructions.
  assign w_unused   = ^i_jump_addr[1:0];

  assign o_imem_req    = (r_state == ST_REQ);
  assign o_imem_addr   = (r_state == ST_REQ) ? {r_pc[31:4], 4'b0000} : 32'h0;
  assign o_fetch_data  = r_fetch_data;
  assign o_fetch_write = r_fetch_write;
  assign o_fetch_pc    = r_fetch_pc;

  // Replace slots before a misaligned jump target with NOPs.
  always_comb begin
    w_bundle = i_imem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < r_skip) w_bundle[i*32 +: 32] = NOP_INSTR;
    end
  end

  // Next-state logic; a redirect overrides every other event.
  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_skip_d        = r_skip;
    w_hold_d        = r_hold;
    w_hold_pc_d     = r_hold_pc;
    w_fetch_write_d = 1'b0;
    w_fetch_data_d  = r_fetch_data;
    w_fetch_pc_d    = r_fetch_pc;
    if (w_redirect) begin
      w_pc_d      = {i_jump_addr[31:4], 4'b0000};
      w_skip_d    = i_jump_addr[3:2];
      w_hold_d    = '0;
      w_hold_pc_d = '0;
      case (r_state)
        ST_IDLE:  w_state_d = i_stop_fetch ? ST_IDLE : ST_REQ;
        // Ungranted request is simply re-presented with the new address.
        ST_REQ:   w_state_d = i_imem_gnt ? ST_DRAIN : ST_REQ;
        ST_WAIT: begin
          if (i_imem_valid) w_state_d = i_stop_fetch ? ST_IDLE : ST_REQ;
          else              w_state_d = ST_DRAIN;
        end
        ST_HOLD:  w_state_d = i_stop_fetch ? ST_IDLE : ST_REQ;
        // Response arriving with the redirect ends the drain; otherwise keep waiting.
        ST_DRAIN: begin
          if (i_imem_valid) w_state_d = i_stop_fetch ? ST_IDLE : ST_REQ;
        end
        default:  w_state_d = ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!i_stop_fetch) w_state_d = ST_REQ;
        end
        ST_REQ: begin
          if (i_imem_gnt) w_state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (i_imem_valid) begin
            w_skip_d = 2'd0;
            w_pc_d   = r_pc + 32'd16;
            if (!i_stop_fetch) begin
              w_fetch_write_d = 1'b1;
              w_fetch_data_d  = w_bundle;
              w_fetch_pc_d    = r_pc;
              w_state_d       = ST_REQ;
            end else begin
              w_hold_d    = w_bundle;
              w_hold_pc_d = r_pc;
              w_state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!i_stop_fetch) begin
            w_fetch_write_d = 1'b1;
            w_fetch_data_d  = r_hold;
            w_fetch_pc_d    = r_hold_pc;
            w_state_d       = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (i_imem_valid) w_state_d = i_stop_fetch ? ST_IDLE : ST_REQ;
        end
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_skip        <= 2'd0;
      r_hold        <= '0;
      r_hold_pc     <= '0;
      r_fetch_data  <= '0;
      r_fetch_write <= 1'b0;
      r_fetch_pc    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_skip        <= w_skip_d;
      r_hold        <= w_hold_d;
      r_hold_pc     <= w_hold_pc_d;
      r_fetch_data  <= w_fetch_data_d;
      r_fetch_write <= w_fetch_write_d;
      r_fetch_pc    <= w_fetch_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic        w_squash;
  logic [31:0] r_perf_bundles;
  logic [15:0] r_perf_squash;

  // A response is thrown away when it lands in DRAIN, collides with a redirect
  // in WAIT, or is sitting in HOLD when a redirect arrives.
  always_comb begin
    w_squash = (i_imem_valid && ((r_state == ST_DRAIN) || (r_state == ST_WAIT && w_redirect)))
             || (r_state == ST_HOLD && w_redirect);
  end

  // Performance counters; the squash count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_bundles <= '0;
      r_perf_squash  <= '0;
    end else begin
      if (w_fetch_write_d) r_perf_bundles <= r_perf_bundles + 32'd1;
      if (w_squash && (r_perf_squash != 16'hFFFF)) r_perf_squash <= r_perf_squash + 16'd1;
    end
  end

  assign o_perf_bundles = r_perf_bundles;
  assign o_perf_squash  = r_perf_squash;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic         clk;
  logic         rst_n;
  logic         stop_fetch;
  logic         jump;
  logic         jump_accept;
  logic [31:0]  jump_addr;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_valid;
  logic [127:0] imem_rdata;
  logic [127:0] fetch_data;
  logic         fetch_write;
  logic [31:0]  fetch_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_bundles;
  logic [15:0]  perf_squash;
`endif

  int n_tests;
  int n_fail;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_stop_fetch  (stop_fetch),
    .i_jump        (jump),
    .i_jump_accept (jump_accept),
    .i_jump_addr   (jump_addr),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_valid  (imem_valid),
    .i_imem_rdata  (imem_rdata),
    .o_fetch_data  (fetch_data),
    .o_fetch_write (fetch_write),
    .o_fetch_pc    (fetch_pc)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_bundles (perf_bundles),
    .o_perf_squash  (perf_squash)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each slot tagged with its byte address.
  function automatic logic [127:0] data_for(input logic [31:0] a);
    return {a ^ 32'hDEAD_000C, a ^ 32'hDEAD_0008, a ^ 32'hDEAD_0004, a ^ 32'hDEAD_0000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    jump        = 1'b0;
    jump_accept = 1'b0;
    jump_addr   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    for (int i = 0; i < 8 && !imem_req; i++) step();
    ok = imem_req;
  endtask

  task automatic grant();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] a, input int delay);
    repeat (delay) step();
    imem_valid = 1'b1;
    imem_rdata = data_for(a);
    step();
    imem_valid = 1'b0;
  endtask

  task automatic test_reset();
    stop_fetch = 1'b0;
    rst_n      = 1'b0;
    imem_gnt   = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    jump       = 1'b0;
    jump_accept = 1'b0;
    jump_addr  = '0;
    #12;
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_tests++;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    n_tests++;
    if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", fetch_write); end
    n_tests++;
    if (fetch_data !== 128'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", fetch_data); end
    n_tests++;
    if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", fetch_pc); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] a;
    do_reset();
    stop_fetch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i) * 32'd16;
      wait_req(ok);
      n_tests++;
      if (!ok || imem_addr !== a) begin
        n_fail++; $display("FAIL seq_addr got req=%b addr=%h want addr=%h", ok, imem_addr, a);
      end
      grant();
      respond(a, 0);
      n_tests++;
      if (fetch_write !== 1'b1 || fetch_pc !== a) begin
        n_fail++; $display("FAIL seq_write got w=%b pc=%h want w=1 pc=%h", fetch_write, fetch_pc, a);
      end
      n_tests++;
      if (fetch_data !== data_for(a)) begin
        n_fail++; $display("FAIL seq_data got %h want %h", fetch_data, data_for(a));
      end
    end
    step();
    n_tests++;
    if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL seq_pulse got %b want 0", fetch_write); end
    n_tests++;
    if (fetch_data !== data_for(32'h20) || fetch_pc !== 32'h20) begin
      n_fail++; $display("FAIL seq_holdval got pc=%h want pc=00000020", fetch_pc);
    end
  endtask

  task automatic test_stop_hold();
    bit ok;
    bit bad;
    do_reset();
    stop_fetch = 1'b0;
    wait_req(ok);
    grant();
    respond(32'h0, 0);
    n_tests++;
    if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL hold_pre got %h want 00000010", imem_addr); end
    grant();
    stop_fetch = 1'b1;
    respond(32'h10, 1);
    n_tests++;
    if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL hold_nowrite got %b want 0", fetch_write); end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fetch_write !== 1'b0 || imem_req !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL hold_quiet got activity=1 want 0"); end
    stop_fetch = 1'b0;
    step();
    n_tests++;
    if (fetch_write !== 1'b1 || fetch_pc !== 32'h10) begin
      n_fail++; $display("FAIL hold_release got w=%b pc=%h want w=1 pc=00000010", fetch_write, fetch_pc);
    end
    n_tests++;
    if (fetch_data !== data_for(32'h10)) begin
      n_fail++; $display("FAIL hold_data got %h want %h", fetch_data, data_for(32'h10));
    end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL hold_next got req=%b addr=%h want req=1 addr=00000020", imem_req, imem_addr);
    end
    step();
    n_tests++;
    if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL hold_pulse got %b want 0", fetch_write); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    logic [127:0] exp;
    do_reset();
    stop_fetch = 1'b0;
    wait_req(ok);
    grant();
    respond(32'h0, 0);
    grant();
    jump        = 1'b1;
    jump_accept = 1'b1;
    jump_addr   = 32'h108;
    step();
    jump        = 1'b0;
    jump_accept = 1'b0;
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_req got %b want 0", imem_req); end
    respond(32'h10, 0);
    n_tests++;
    if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL drain_drop got %b want 0", fetch_write); end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_addr got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
    end
    grant();
    respond(32'h100, 0);
    exp = data_for(32'h100);
    exp[63:0] = {32'h0000_0013, 32'h0000_0013};
    n_tests++;
    if (fetch_write !== 1'b1 || fetch_pc !== 32'h100) begin
      n_fail++; $display("FAIL redir_write got w=%b pc=%h want w=1 pc=00000100", fetch_write, fetch_pc);
    end
    n_tests++;
    if (fetch_data !== exp) begin n_fail++; $display("FAIL redir_skip got %h want %h", fetch_data, exp); end
    grant();
    respond(32'h110, 0);
    n_tests++;
    if (fetch_data !== data_for(32'h110) || fetch_pc !== 32'h110) begin
      n_fail++; $display("FAIL skip_clear got %h want %h", fetch_data, data_for(32'h110));
    end
  endtask

  task automatic test_jump_with_valid();
    bit ok;
    do_reset();
    stop_fetch = 1'b0;
    wait_req(ok);
    grant();
    respond(32'h0, 0);
    grant();
    imem_valid  = 1'b1;
    imem_rdata  = data_for(32'h10);
    jump        = 1'b1;
    jump_accept = 1'b1;
    jump_addr   = 32'h200;
    step();
    imem_valid  = 1'b0;
    jump        = 1'b0;
    jump_accept = 1'b0;
    n_tests++;
    if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL jv_nowrite got %b want 0", fetch_write); end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL jv_addr got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr);
    end
    // Jump without accept must be ignored.
    jump      = 1'b1;
    jump_addr = 32'h400;
    grant();
    jump = 1'b0;
    respond(32'h200, 0);
    n_tests++;
    if (fetch_write !== 1'b1 || fetch_pc !== 32'h200) begin
      n_fail++; $display("FAIL noaccept_write got w=%b pc=%h want w=1 pc=00000200", fetch_write, fetch_pc);
    end
    n_tests++;
    if (fetch_data !== data_for(32'h200)) begin
      n_fail++; $display("FAIL noaccept_data got %h want %h", fetch_data, data_for(32'h200));
    end
    n_tests++;
    if (imem_addr !== 32'h210) begin n_fail++; $display("FAIL noaccept_next got %h want 00000210", imem_addr); end
  endtask

  task automatic test_pc_wrap();
    bit ok;
    stop_fetch = 1'b1;
    do_reset();
    jump        = 1'b1;
    jump_accept = 1'b1;
    jump_addr   = 32'hFFFF_FFF0;
    step();
    jump        = 1'b0;
    jump_accept = 1'b0;
    stop_fetch  = 1'b0;
    wait_req(ok);
    n_tests++;
    if (!ok || imem_addr !== 32'hFFFF_FFF0) begin
      n_fail++; $display("FAIL wrap_first got req=%b addr=%h want addr=fffffff0", ok, imem_addr);
    end
    grant();
    respond(32'hFFFF_FFF0, 2);
    n_tests++;
    if (fetch_write !== 1'b1 || fetch_pc !== 32'hFFFF_FFF0) begin
      n_fail++; $display("FAIL wrap_write got w=%b pc=%h want w=1 pc=fffffff0", fetch_write, fetch_pc);
    end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    stop_fetch = 1'b0;
    wait_req(ok);
    grant();
    respond(32'h0, 0);
    grant();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (imem_req !== 1'b0 || fetch_write !== 1'b0 || fetch_pc !== 32'h0) begin
      n_fail++; $display("FAIL rmid_clear got req=%b w=%b pc=%h want 0 0 0", imem_req, fetch_write, fetch_pc);
    end
    step();
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = data_for(32'h10);
    step();
    n_tests++;
    if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL rmid_stray got %b want 0", fetch_write); end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rmid_restart got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
    end
    step();
    imem_valid = 1'b0;
    n_tests++;
    if (fetch_write !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rmid_req_stray got w=%b addr=%h want w=0 addr=00000000", fetch_write, imem_addr);
    end
`ifdef FETCH_PERF_EN
    n_tests++;
    if (perf_bundles !== 32'h0 || perf_squash !== 16'h0) begin
      n_fail++; $display("FAIL rmid_perf got b=%0d s=%0d want 0 0", perf_bundles, perf_squash);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sequential();
    test_stop_hold();
    test_redirect_wait();
    test_jump_with_valid();
    test_pc_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
